rgbw_scale_sequencer: RTL and testbench

Scheduler that time-shares the single 8x8 multiplier (mult8x8) across the four colour channels. It scales the red, green, blue and white set-points by the intensity byte (lint) and produces the four duty bytes consumed by pwmGen. Commits are atomic, so the PWM never sees a mix of old and new channel values. It sits between the SPI data dispenser/colorGen registers and pwmGen, and is the only master of the multiplier.

---
 rtl/rgbw_scale_sequencer_if.sv | 18 +
 rtl/rgbw_scale_sequencer.sv | 138 +++++++++++++
 tb/tb_rgbw_scale_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgbw_scale_sequencer_if.sv
// Multiplier handshake bundle shared by the channel sequencer (master) and mult8x8 (slave).
interface rgbw_scale_sequencer_if;
   logic        mult_ld;
   logic [7:0]  mult_a;
   logic [7:0]  mult_b;
   logic [15:0] mult_res;
   logic        mult_rdy;

   modport master (
      output mult_ld, mult_a, mult_b,
      input  mult_res, mult_rdy
   );

   modport slave (
      input  mult_ld, mult_a, mult_b,
      output mult_res, mult_rdy
   );
endinterface

// File: rtl/rgbw_scale_sequencer.sv
// Time-shares one 8x8 multiplier across R,G,B,W to scale set-points by intensity,
// then commits all four duty bytes atomically on a clk_half strobe.
module rgbw_scale_sequencer #(
   parameter int unsigned MULT_TIMEOUT = 16,
   parameter int unsigned TO_W         = 5
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          clk_half_i,
   input  logic                          start_i,
   input  logic [7:0]                    lint_i,
   input  logic [7:0]                    red_i,
   input  logic [7:0]                    green_i,
   input  logic [7:0]                    blue_i,
   input  logic [7:0]                    white_i,
   rgbw_scale_sequencer_if.master        mult_if,
   output logic [7:0]                    red_o,
   output logic [7:0]                    green_o,
   output logic [7:0]                    blue_o,
   output logic [7:0]                    white_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o
);

   typedef enum logic [2:0] {StIdle, StLoad, StWait, StStore, StCommit} state_e;

   state_e           state_q, state_d;
   logic [1:0]       idx_q;
   logic [3:0][7:0]  snap_q;
   logic [7:0]       lint_q;
   logic [3:0][7:0]  shadow_q;
   logic [3:0][7:0]  out_q;
   logic [TO_W-1:0]  cnt_q;
   logic [15:0]      prod_q;
   logic             to_q;
   logic             pend_q;
   logic             err_q;

   logic             accept;
   logic             commit;
   logic             timeout_hit;
   logic [7:0]       scaled;

   assign timeout_hit = !mult_if.mult_rdy && (cnt_q == TO_W'(MULT_TIMEOUT - 1));
   // a*lint + a fits in 16 bits, so the top byte is the rounded-down a*(lint+1)/256.
   assign scaled = 8'((prod_q + {8'h00, snap_q[idx_q]}) >> 8);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start_i || pend_q) state_d = StLoad;
         StLoad:   state_d = StWait;
         StWait:   if (mult_if.mult_rdy || timeout_hit) state_d = StStore;
         StStore:  state_d = (idx_q == 2'd3) ? StCommit : StLoad;
         StCommit: if (clk_half_i) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      mult_if.mult_ld = (state_q == StLoad);
      busy_o          = (state_q != StIdle);
      commit          = (state_q == StCommit) && clk_half_i;
      done_o          = commit;
      accept          = (state_q == StIdle) && (start_i || pend_q);
   end

   assign mult_if.mult_a = snap_q[idx_q];
   assign mult_if.mult_b = lint_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         idx_q    <= '0;
         snap_q   <= '0;
         lint_q   <= '0;
         shadow_q <= '0;
         out_q    <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         to_q     <= 1'b0;
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // Starts arriving while a run is in flight (including the commit cycle) merge into one.
         if (accept) begin
            pend_q <= 1'b0;
         end else if (start_i && (state_q != StIdle)) begin
            pend_q <= 1'b1;
         end

         if (accept) begin
            snap_q <= {white_i, blue_i, green_i, red_i};
            lint_q <= lint_i;
            idx_q  <= 2'd0;
            err_q  <= 1'b0;
         end

         if (state_q == StLoad) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
         end

         if (state_q == StWait) begin
            if (mult_if.mult_rdy) begin
               prod_q <= mult_if.mult_res;
            end else if (timeout_hit) begin
               to_q  <= 1'b1;
               err_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         if (state_q == StStore) begin
            shadow_q[idx_q] <= to_q ? 8'h00 : scaled;
            if (idx_q != 2'd3) idx_q <= idx_q + 2'd1;
         end

         if (commit) out_q <= shadow_q;
      end
   end

   assign red_o   = out_q[0];
   assign green_o = out_q[1];
   assign blue_o  = out_q[2];
   assign white_o = out_q[3];
   assign err_o   = err_q;

endmodule

// File: tb/tb_rgbw_scale_sequencer.sv
// Randomized bench for rgbw_scale_sequencer: behavioural multiplier with variable latency,
// arithmetic reference for channel scaling, and scenario tasks run in sequence.
module tb_rgbw_scale_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_half;
   logic        start;
   logic [7:0]  lint, r_in, g_in, b_in, w_in;
   logic [7:0]  r_out, g_out, b_out, w_out;
   logic        busy, done, err;

   rgbw_scale_sequencer_if mif ();

   rgbw_scale_sequencer #(
      .MULT_TIMEOUT (16),
      .TO_W         (5)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .clk_half_i (clk_half),
      .start_i    (start),
      .lint_i     (lint),
      .red_i      (r_in),
      .green_i    (g_in),
      .blue_i     (b_in),
      .white_i    (w_in),
      .mult_if    (mif.master),
      .red_o      (r_out),
      .green_o    (g_out),
      .blue_o     (b_out),
      .white_o    (w_out),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_out = '0;
   int last_lat = 0;

   // clk_half: high one cycle in half_div, updated shortly after the rising edge.
   int half_div = 1;
   int ch_cnt = 0;
   always @(posedge clk) begin
      #2;
      ch_cnt++;
      clk_half = ((ch_cnt % half_div) == 0);
   end

   // Multiplier model: product after 0..3 extra cycles; the load numbered hold_at is never answered.
   int ld_n = 0;
   int hold_at = -1;
   int fixed_lat = -1;
   int wait_n = 0;
   bit armed = 1'b0;
   bit spur = 1'b0;
   logic [15:0] res_hold;
   always @(posedge clk) begin
      int lat;
      mif.mult_rdy <= 1'b0;
      if (spur) begin
         mif.mult_rdy <= 1'b1;
         mif.mult_res <= 16'hffff;
      end
      if (mif.mult_ld) begin
         ld_n <= ld_n + 1;
         if (ld_n != hold_at) begin
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            if (lat == 0) begin
               mif.mult_rdy <= 1'b1;
               mif.mult_res <= 16'(mif.mult_a) * 16'(mif.mult_b);
            end else begin
               armed    <= 1'b1;
               wait_n   <= lat - 1;
               res_hold <= 16'(mif.mult_a) * 16'(mif.mult_b);
            end
         end
      end else if (armed) begin
         if (wait_n == 0) begin
            mif.mult_rdy <= 1'b1;
            mif.mult_res <= res_hold;
            armed        <= 1'b0;
         end else begin
            wait_n <= wait_n - 1;
         end
      end
   end

   function automatic logic [7:0] scale(input int a, input int l);
      return 8'((a * (l + 1)) / 256);
   endfunction

   function automatic logic [31:0] outs();
      return {w_out, b_out, g_out, r_out};
   endfunction

   task automatic wait_done(output bit seen);
      int n;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 300) begin
         @(negedge clk);
         start = 1'b0;
         n++;
         if (done) seen = 1'b1;
      end
   endtask

   // One full run; inputs are scrambled every cycle after the start to prove the snapshot holds.
   task automatic run_once(input logic [7:0] l, r, g, b, w, input bit hold_g);
      logic [31:0] e;
      bit seen, stable;
      int n;
      e = {scale(w, l), scale(b, l), hold_g ? 8'h00 : scale(g, l), scale(r, l)};
      @(negedge clk);
      hold_at = hold_g ? ld_n + 1 : -1;
      lint = l; r_in = r; g_in = g; b_in = b; w_in = w;
      start = 1'b1;
      seen = 1'b0; stable = 1'b1; n = 0;
      while (!seen && n < 300) begin
         @(negedge clk);
         start = 1'b0;
         n++;
         if (outs() !== exp_out) stable = 1'b0;
         if (done) seen = 1'b1;
         else {lint, r_in, g_in, b_in, w_in} = {8'($urandom), $urandom};
      end
      last_lat = n;
      checks++;
      if (!seen) begin errors++; $display("FAIL done_timeout: no done within %0d cycles", n); end
      checks++;
      if (!stable) begin errors++; $display("FAIL early_change: outputs moved before commit"); end
      checks++;
      if (clk_half !== 1'b1) begin
         errors++; $display("FAIL commit_gate: clk_half=%b at done, want 1", clk_half);
      end
      @(negedge clk);
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL outputs: got %h want %h", outs(), e); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b want 0", done); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_after: busy=%b want 0", busy); end
      checks++;
      if (err !== hold_g) begin errors++; $display("FAIL err_flag: err=%b want %b", err, hold_g); end
      exp_out = e;
      hold_at = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (outs() !== 32'h0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs()); end
      checks++;
      if ({busy, done, err} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: busy/done/err=%b want 000", {busy, done, err});
      end
      checks++;
      if (mif.mult_ld !== 1'b0) begin errors++; $display("FAIL reset_ld: mult_ld=%b want 0", mif.mult_ld); end
   endtask

   task automatic test_basic();
      half_div = 1;
      fixed_lat = 0;
      run_once(8'd128, 8'd200, 8'd100, 8'd255, 8'd1, 1'b0);
      checks++;
      if (outs() !== {8'd0, 8'd128, 8'd50, 8'd100}) begin
         errors++; $display("FAIL basic_values: got %h want 00803264", outs());
      end
      checks++;
      if (last_lat != 13) begin errors++; $display("FAIL latency: done at cycle %0d want 13", last_lat); end
      fixed_lat = -1;
   endtask

   task automatic test_endpoints();
      run_once(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
      checks++;
      if (outs() !== 32'hffff_ffff) begin errors++; $display("FAIL lint255: got %h want ffffffff", outs()); end
      run_once(8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
      checks++;
      if (outs() !== 32'h0) begin errors++; $display("FAIL lint0: got %h want 0", outs()); end
   endtask

   task automatic test_random();
      repeat (12) begin
         half_div = int'($urandom_range(1, 4));
         run_once(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      end
   endtask

   task automatic test_clk_half();
      half_div = 4;
      repeat (3) run_once(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      half_div = 1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] e1, e2;
      logic [7:0] g2, b2, w2;
      bit seen;
      int extra;
      half_div = 1;
      @(negedge clk);
      lint = 8'd128; r_in = 8'd200; g_in = 8'd100; b_in = 8'd255; w_in = 8'd1;
      e1 = {8'd0, 8'd128, 8'd50, 8'd100};
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      g2 = 8'($urandom); b2 = 8'($urandom); w2 = 8'($urandom);
      lint = 8'd64; r_in = 8'd255; g_in = g2; b_in = b2; w_in = w2;
      e2 = {scale(w2, 64), scale(b2, 64), scale(g2, 64), 8'd64};
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1;
      wait_done(seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL b2b_done1: first commit missing"); end
      @(negedge clk);
      checks++;
      if (outs() !== e1) begin errors++; $display("FAIL b2b_first: got %h want %h", outs(), e1); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: busy=%b want 0", busy); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: busy=%b want 1", busy); end
      wait_done(seen);
      @(negedge clk);
      checks++;
      if (outs() !== e2) begin errors++; $display("FAIL b2b_second: got %h want %h", outs(), e2); end
      extra = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL b2b_merge: busy %0d cycles after second run, want 0", extra); end
      exp_out = e2;
   endtask

   task automatic test_timeout();
      half_div = 1;
      run_once(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      run_once(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
   endtask

   task automatic test_spurious();
      @(negedge clk); spur = 1'b1;
      @(negedge clk); spur = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (outs() !== exp_out || busy !== 1'b0) begin
         errors++; $display("FAIL spurious_rdy: outs=%h busy=%b want %h busy=0", outs(), busy, exp_out);
      end
   endtask

   task automatic test_reset_mid();
      int stray;
      half_div = 1;
      run_once(8'd128, 8'd200, 8'd100, 8'd255, 8'd1, 1'b0);
      @(negedge clk);
      lint = 8'd200; r_in = 8'd99; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      checks++;
      if (outs() !== 32'h0) begin errors++; $display("FAIL midreset_outs: got %h want 0", outs()); end
      checks++;
      if (busy !== 1'b0 || mif.mult_ld !== 1'b0) begin
         errors++; $display("FAIL midreset_ctl: busy=%b mult_ld=%b want 0 0", busy, mif.mult_ld);
      end
      reset = 1'b0;
      exp_out = '0;
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL stale_pending: busy %0d cycles, want 0", stray); end
      run_once(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
   endtask

   initial begin
      start = 1'b0;
      {lint, r_in, g_in, b_in, w_in} = '0;
      test_reset();
      test_basic();
      test_endpoints();
      test_random();
      test_clk_half();
      test_back_to_back();
      test_timeout();
      test_spurious();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
